// File: rtl/keccak_msg_feeder_if.sv
// rtl/keccak_msg_feeder_if.sv - byte-stream and keccak core word-port bundle for the message feeder
interface keccak_msg_feeder_if;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic         core_reset;
  logic [31:0]  in;
  logic         in_ready;
  logic         is_last;
  logic [1:0]   byte_num;
  logic         buffer_full;
  logic [511:0] out;
  logic         out_ready;

  modport master (
    input  s_data, s_valid, s_last, buffer_full, out, out_ready,
    output s_ready, core_reset, in, in_ready, is_last, byte_num
  );

  modport slave (
    output s_data, s_valid, s_last, buffer_full, out, out_ready,
    input  s_ready, core_reset, in, in_ready, is_last, byte_num
  );
endinterface

// File: rtl/keccak_msg_feeder.sv
// rtl/keccak_msg_feeder.sv - packs a byte stream into big-endian words for the keccak core and latches its digest
module keccak_msg_feeder #(
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  keccak_msg_feeder_if.master  bus,
  output logic [511:0]         digest,
  output logic                 done,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_PAD   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0]    state;
  logic [23:0]   acc;
  logic [1:0]    cnt;
  logic [31:0]   word;
  logic          word_vld;
  logic          word_last;
  logic [1:0]    word_bn;
  logic [TW-1:0] timer;

  logic          accept;
  logic          slot_free;
  logic          s_ready;
  logic          fire;
  logic [31:0]   last_word;

  assign bus.in         = word;
  assign bus.in_ready   = word_vld;
  assign bus.is_last    = word_last;
  assign bus.byte_num   = word_bn;
  assign bus.core_reset = (state == S_CLEAR);
  assign bus.s_ready    = s_ready;
  assign busy           = (state != S_IDLE);

  assign accept    = word_vld & ~bus.buffer_full;
  assign slot_free = ~word_vld | accept;
  // A byte that completes a word (4th or last) needs the output slot; others only fill the accumulator.
  assign s_ready   = (state == S_FEED) && (slot_free || ((cnt != 2'd3) && !bus.s_last));
  assign fire      = bus.s_valid & s_ready;

  always_comb begin
    last_word = '0;
    case (cnt)
      2'd0:    last_word = {bus.s_data, 24'h0};
      2'd1:    last_word = {acc[7:0], bus.s_data, 16'h0};
      2'd2:    last_word = {acc[15:0], bus.s_data, 8'h0};
      default: last_word = {acc, bus.s_data};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      acc         <= '0;
      cnt         <= '0;
      word        <= '0;
      word_vld    <= 1'b0;
      word_last   <= 1'b0;
      word_bn     <= '0;
      timer       <= '0;
      digest      <= '0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      done        <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.s_valid) state <= S_CLEAR;
        end
        S_CLEAR: begin
          cnt   <= '0;
          acc   <= '0;
          state <= S_FEED;
        end
        S_FEED: begin
          if (accept) word_vld <= 1'b0;
          if (fire) begin
            if (bus.s_last) begin
              word     <= last_word;
              word_vld <= 1'b1;
              cnt      <= '0;
              acc      <= '0;
              if (cnt == 2'd3) begin
                // Exactly word-aligned: the core still needs an empty terminating word.
                word_last <= 1'b0;
                word_bn   <= '0;
                state     <= S_PAD;
              end else begin
                word_last <= 1'b1;
                word_bn   <= cnt + 2'd1;
                state     <= S_DRAIN;
              end
            end else if (cnt == 2'd3) begin
              word      <= {acc, bus.s_data};
              word_vld  <= 1'b1;
              word_last <= 1'b0;
              word_bn   <= '0;
              cnt       <= '0;
            end else begin
              acc <= {acc[15:0], bus.s_data};
              cnt <= cnt + 2'd1;
            end
          end
        end
        S_PAD: begin
          if (accept) begin
            word      <= '0;
            word_last <= 1'b1;
            word_bn   <= '0;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (accept) begin
            word      <= '0;
            word_vld  <= 1'b0;
            word_last <= 1'b0;
            word_bn   <= '0;
            timer     <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.out_ready) begin
            digest <= bus.out;
            done   <= 1'b1;
            state  <= S_IDLE;
          end else if ((TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1))) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_msg_feeder.sv
// tb/tb_keccak_msg_feeder.sv - randomized self-checking bench for keccak_msg_feeder
module tb_keccak_msg_feeder;

  logic         clk = 1'b0;
  logic         reset;
  logic [511:0] digest;
  logic         done;
  logic         busy;
  logic         err_timeout;

  keccak_msg_feeder_if bus();

  keccak_msg_feeder #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .digest      (digest),
    .done        (done),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  msg_q[$];
  logic [34:0] exp_q[$];
  logic [34:0] got_q[$];

  int          n_core_reset, stab_err, bn_err, sr_low_stall;
  logic        held_valid;
  logic [34:0] held;
  logic        byte_fire, sr_obs, cr_obs, done_obs, busy_obs, err_obs;
  logic [511:0] dig_obs;
  logic [511:0] digest_model;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Expected core words: big-endian chunks of 4, zero-filled tail, empty pad word when length is a multiple of 4.
  function automatic void build_exp();
    int n;
    int nw;
    int rem;
    logic [31:0] w;
    n   = msg_q.size();
    nw  = (n + 3) / 4;
    rem = n % 4;
    exp_q.delete();
    for (int wi = 0; wi < nw; wi++) begin
      w = '0;
      for (int b = 0; b < 4; b++)
        if (wi * 4 + b < n) w[31 - 8*b -: 8] = msg_q[wi * 4 + b];
      if (wi == nw - 1 && rem != 0) exp_q.push_back({1'b1, 2'(rem), w});
      else                          exp_q.push_back({1'b0, 2'd0, w});
    end
    if (rem == 0) exp_q.push_back({1'b1, 2'd0, 32'h0});
  endfunction

  function automatic void msg_from_str(input string s);
    msg_q.delete();
    for (int k = 0; k < s.len(); k++) msg_q.push_back(s[k]);
  endfunction

  function automatic void msg_random(input int len);
    msg_q.delete();
    for (int k = 0; k < len; k++) msg_q.push_back(8'($urandom));
  endfunction

  // Inputs are set just after a rising edge; everything is observed on the falling edge.
  task automatic step();
    logic [34:0] cur;
    @(negedge clk);
    cur = {bus.is_last, bus.byte_num, bus.in};
    if (reset) begin
      if (bus.core_reset) n_core_reset++;
      if (bus.in_ready && !bus.buffer_full) got_q.push_back(cur);
      if (held_valid && cur !== held) stab_err++;
      if (!bus.is_last && bus.byte_num != 2'd0) bn_err++;
      held_valid = bus.in_ready && bus.buffer_full;
      held       = cur;
    end else begin
      held_valid = 1'b0;
    end
    byte_fire = bus.s_valid && bus.s_ready;
    sr_obs    = bus.s_ready;
    cr_obs    = bus.core_reset;
    done_obs  = done;
    busy_obs  = busy;
    err_obs   = err_timeout;
    dig_obs   = digest;
    @(posedge clk);
    #1;
  endtask

  function automatic logic bf_for(input int mode, input int cyc);
    if (mode == 1) return ($urandom_range(0, 2) == 0);
    if (mode == 2) return (cyc >= 6 && cyc <= 10);
    return 1'b0;
  endfunction

  task automatic run_msg(input int mode);
    int i;
    int cyc;
    build_exp();
    got_q.delete();
    n_core_reset = 0; stab_err = 0; bn_err = 0; sr_low_stall = 0;
    i = 0; cyc = 0;
    while (i < msg_q.size() && cyc < 500) begin
      bus.s_valid     = (i == 0 || mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
      bus.s_data      = msg_q[i];
      bus.s_last      = (i == msg_q.size() - 1);
      bus.buffer_full = bf_for(mode, cyc);
      step();
      if (cyc == 0) check("idle_s_ready", 512'(sr_obs), 512'(0));
      if (cyc == 1) begin
        check("clear_s_ready", 512'(sr_obs), 512'(0));
        check("clear_core_reset", 512'(cr_obs), 512'(1));
      end
      if (mode == 2 && bus.buffer_full && !sr_obs && cyc >= 2) sr_low_stall++;
      if (byte_fire) i++;
      cyc++;
    end
    check("bytes_sent", 512'(i), 512'(msg_q.size()));
    bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_data = '0;
    while (got_q.size() < exp_q.size() && cyc < 500) begin
      bus.buffer_full = bf_for(mode, cyc);
      step();
      cyc++;
    end
    bus.buffer_full = 1'b0;
    check("word_count", 512'(got_q.size()), 512'(exp_q.size()));
    foreach (exp_q[k])
      if (k < got_q.size()) check($sformatf("word%0d", k), 512'(got_q[k]), 512'(exp_q[k]));
    check("core_reset_pulses", 512'(n_core_reset), 512'(1));
    check("stable_under_stall", 512'(stab_err), 512'(0));
    check("byte_num_zero", 512'(bn_err), 512'(0));
    if (mode == 2) check("s_ready_drop", 512'(sr_low_stall > 0), 512'(1));
  endtask

  task automatic finish_digest();
    int dly;
    dly = $urandom_range(0, 2);
    for (int k = 0; k < dly; k++) begin
      step();
      check("wait_busy", 512'(busy_obs), 512'(1));
    end
    bus.out       = rand512();
    digest_model  = bus.out;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    bus.out       = rand512();
    step();
    check("done_pulse", 512'(done_obs), 512'(1));
    check("digest", dig_obs, digest_model);
    check("idle_busy", 512'(busy_obs), 512'(0));
    step();
    check("done_one_cycle", 512'(done_obs), 512'(0));
  endtask

  initial begin
    int err_at;
    int err_cnt;
    int done_cnt;
    logic busy_at_err;
    reset = 1'b0;
    bus.s_data = '0; bus.s_valid = 1'b0; bus.s_last = 1'b0;
    bus.buffer_full = 1'b0; bus.out = '0; bus.out_ready = 1'b0;
    held_valid = 1'b0; held = '0;
    digest_model = '0;
    repeat (3) step();
    reset = 1'b1;
    step();
    check("rst_in_ready", 512'(bus.in_ready), 512'(0));
    check("rst_core_reset", 512'(bus.core_reset), 512'(0));
    check("rst_s_ready", 512'(bus.s_ready), 512'(0));
    check("rst_digest", digest, 512'(0));
    check("rst_busy_done_err", 512'({busy, done, err_timeout}), 512'(0));

    bus.out = rand512(); bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    step();
    check("idle_out_ready_done", 512'(done_obs), 512'(0));
    check("idle_out_ready_digest", dig_obs, 512'(0));

    msg_from_str("Hello, world!");
    run_msg(0);
    check("hello13_tail", 512'(got_q[3]), 512'({1'b1, 2'd1, 32'h21000000}));
    finish_digest();

    msg_from_str("Hello, world");
    run_msg(0);
    check("hello12_pad", 512'(got_q[3]), 512'({1'b1, 2'd0, 32'h0}));
    finish_digest();

    msg_from_str("dog ");
    run_msg(1);
    check("dog4_word", 512'(got_q[0]), 512'({1'b0, 2'd0, 32'h646F6720}));
    finish_digest();

    msg_from_str("dog");
    run_msg(0);
    check("dog3_word", 512'(got_q[0]), 512'({1'b1, 2'd3, 32'h646F6700}));
    finish_digest();

    msg_from_str("Hello, world!");
    run_msg(2);
    finish_digest();

    for (int t = 0; t < 6; t++) begin
      msg_random($urandom_range(1, 20));
      run_msg(t % 2);
      finish_digest();
    end

    // Reset in the middle of a message.
    msg_random(8);
    got_q.delete();
    n_core_reset = 0;
    begin
      int i;
      i = 0;
      for (int c = 0; c < 7; c++) begin
        bus.s_valid = 1'b1; bus.s_data = msg_q[i]; bus.s_last = 1'b0;
        step();
        if (byte_fire) i++;
      end
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    bus.s_valid = 1'b0;
    check("mid_rst_word", 512'({bus.in_ready, bus.is_last, bus.byte_num, bus.in}), 512'(0));
    check("mid_rst_ctl", 512'({bus.core_reset, bus.s_ready, busy, done, err_timeout}), 512'(0));
    check("mid_rst_digest", digest, 512'(0));
    got_q.delete();
    n_core_reset = 0;
    repeat (3) step();
    check("post_rst_quiet", 512'(got_q.size() + n_core_reset), 512'(0));
    msg_random(3);
    run_msg(0);
    finish_digest();

    // Core never answers: expect a single timeout pulse, digest untouched.
    msg_random(5);
    run_msg(1);
    err_at = 0; err_cnt = 0; done_cnt = 0; busy_at_err = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      step();
      if (err_obs && err_at == 0) begin
        err_at = j;
        busy_at_err = busy_obs;
      end
      if (err_obs) err_cnt++;
      if (done_obs) done_cnt++;
    end
    check("timeout_cycle", 512'(err_at), 512'(17));
    check("timeout_pulses", 512'(err_cnt), 512'(1));
    check("timeout_busy", 512'(busy_at_err), 512'(0));
    check("timeout_no_done", 512'(done_cnt), 512'(0));
    check("timeout_digest", digest, digest_model);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
